// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM encoding, wait-counter
// width and the channel-count limit.
package mem_arb_pkg;

  localparam int unsigned MaxNch   = 8;
  localparam int unsigned WaitCntW = 3;

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StLatch,
    StWaits,
    StDone
  } state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the channel after the
// last accepted winner; the pointer only advances when the grant is accepted.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NCH = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [NCH-1:0] req_i,
  input  logic           accept_i,
  output logic [NCH-1:0] grant_o
);

  localparam int unsigned IdxW = idx_width(NCH);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] win;
  logic            found;
  int unsigned     cand;

  always_comb begin
    grant_o = '0;
    win     = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NCH) begin
        cand = cand - NCH;
      end
      if (!found && req_i[IdxW'(cand)]) begin
        found                 = 1'b1;
        win                   = IdxW'(cand);
        grant_o[IdxW'(cand)]  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && found) begin
      ptr_d = (win == IdxW'(NCH - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel arbiter in front of a synchronous single-port RAM: one access
// at a time, fixed latency of 3+WAIT cycles from request to ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned NCH   = 2,
  parameter int unsigned WAIT  = 1,
  parameter int unsigned DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_wr,
  input  logic [NCH*AW-1:0] ch_adr,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [DW-1:0]     ch_rdata,
  output logic [NCH-1:0]    ch_ack,
  output logic              ch_err,
  output logic [AW-1:0]     ram_adr,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic              busy
);

  state_e                state_q, state_d;
  logic [NCH-1:0]        gnt_q, gnt_d;
  logic                  wr_q, wr_d;
  logic                  oor_q, oor_d;
  logic [AW-1:0]         adr_q, adr_d;
  logic [DW-1:0]         din_q, din_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [NCH-1:0]        ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  busy_q, busy_d;
  logic [WaitCntW-1:0]   cnt_q, cnt_d;

  logic [NCH-1:0]        arb_grant;
  logic                  sel_wr;
  logic [AW-1:0]         sel_adr;
  logic [DW-1:0]         sel_din;
  logic                  sel_oor;

  rr_arbiter #(
    .NCH (NCH)
  ) u_rr_arbiter (
    .clk_i    (clk),
    .rst_ni   (reset),
    .req_i    (ch_req),
    .accept_i (state_q == StIdle),
    .grant_o  (arb_grant)
  );

  // One-hot grant turns the channel mux into a plain OR of masked fields.
  always_comb begin
    sel_wr  = 1'b0;
    sel_adr = '0;
    sel_din = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (arb_grant[i]) begin
        sel_wr  = sel_wr | ch_wr[i];
        sel_adr = sel_adr | ch_adr[i*AW +: AW];
        sel_din = sel_din | ch_wdata[i*DW +: DW];
      end
    end
  end

  assign sel_oor = 64'(sel_adr) >= 64'(DEPTH);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    oor_d   = oor_q;
    adr_d   = adr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    ack_d   = ack_q;
    err_d   = err_q;
    we_d    = we_q;
    re_d    = re_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|ch_req) begin
          state_d = StAccess;
          busy_d  = 1'b1;
          gnt_d   = arb_grant;
          wr_d    = sel_wr;
          adr_d   = sel_adr;
          din_d   = sel_din;
          oor_d   = sel_oor;
          we_d    = sel_wr & ~sel_oor;
          re_d    = ~sel_wr & ~sel_oor;
        end
      end
      StAccess: begin
        we_d    = 1'b0;
        re_d    = 1'b0;
        state_d = StLatch;
      end
      StLatch: begin
        if (!wr_q) begin
          rdata_d = oor_q ? '0 : ram_dout;
        end
        if (WAIT > 0) begin
          state_d = StWaits;
          cnt_d   = WaitCntW'(WAIT - 1);
        end else begin
          state_d = StDone;
          ack_d   = gnt_q;
          err_d   = oor_q;
        end
      end
      StWaits: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          ack_d   = gnt_q;
          err_d   = oor_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        ack_d   = '0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      adr_q   <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      oor_q   <= oor_d;
      adr_q   <= adr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ch_rdata  = rdata_q;
  assign ch_ack    = ack_q;
  assign ch_err    = err_q;
  assign ram_adr   = adr_q;
  assign ram_din   = din_q;
  assign ram_wr_en = we_q;
  assign ram_rd_en = re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (WAIT = 1, 0, 7), each with
// its own RAM model; unwritten words read back as {8'hA5, 14'h0, addr[9:0]}.
module tb_mem_arbiter;

  logic             clk;
  logic             rst_n;
  logic [2:0][1:0]  req;
  logic [1:0]       wr;
  logic [63:0]      adr;
  logic [63:0]      wdata;
  logic [2:0][31:0] rdata;
  logic [2:0][31:0] ram_adr;
  logic [2:0][31:0] ram_din;
  logic [2:0][31:0] ram_dout;
  logic [2:0][1:0]  ack;
  logic [2:0]       err;
  logic [2:0]       we;
  logic [2:0]       re;
  logic [2:0]       busy;

  logic [31:0]      mem [3][1024];
  bit               vld [3][1024];

  int               n_vec;
  int               n_err;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WaitG = (g == 0) ? 1 : ((g == 1) ? 0 : 7);
    mem_arbiter #(
      .DW    (32),
      .AW    (32),
      .NCH   (2),
      .WAIT  (WaitG),
      .DEPTH (1024)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .ch_req    (req[g]),
      .ch_wr     (wr),
      .ch_adr    (adr),
      .ch_wdata  (wdata),
      .ch_rdata  (rdata[g]),
      .ch_ack    (ack[g]),
      .ch_err    (err[g]),
      .ram_adr   (ram_adr[g]),
      .ram_din   (ram_din[g]),
      .ram_dout  (ram_dout[g]),
      .ram_wr_en (we[g]),
      .ram_rd_en (re[g]),
      .busy      (busy[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (we[g]) begin
        mem[g][ram_adr[g][9:0]] <= ram_din[g];
        vld[g][ram_adr[g][9:0]] <= 1'b1;
      end
      if (re[g]) begin
        ram_dout[g] <= vld[g][ram_adr[g][9:0]] ? mem[g][ram_adr[g][9:0]]
                                               : {8'hA5, 14'h0, ram_adr[g][9:0]};
      end
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle, then a single-channel request held until ack (bounded).
  task automatic do_txn(input int n, input int ch, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic e, output int nwe, output int nre, output logic stable);
    tick();
    wr[ch]            = w;
    adr[ch*32 +: 32]  = a;
    wdata[ch*32 +: 32] = d;
    req[n][ch]        = 1'b1;
    lat    = 0;
    rd     = '0;
    e      = 1'b0;
    nwe    = 0;
    nre    = 0;
    stable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (we[n]) nwe++;
      if (re[n]) nre++;
      if (ram_adr[n] !== a) stable = 1'b0;
      if (ack[n][ch]) begin
        lat = c;
        rd  = rdata[n];
        e   = err[n];
        break;
      end
    end
    req[n][ch] = 1'b0;
  endtask

  int          lat, nwe, nre, t0, t1, fc;
  logic [31:0] rd, d0, d1;
  logic        e, st, dual, seen;
  logic [1:0]  first;

  initial begin
    n_vec = 0;
    n_err = 0;
    req   = '0;
    wr    = '0;
    adr   = '0;
    wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_busy", busy[0], 0);
    check_eq("rst_ack", ack[0], 0);
    check_eq("rst_err", err[0], 0);
    check_eq("rst_rdata", rdata[0], 0);
    check_eq("rst_ram_adr", ram_adr[0], 0);
    check_eq("rst_ram_din", ram_din[0], 0);
    check_eq("rst_strobes", {we[0], re[0]}, 0);
    check_eq("rst_busy_w7", busy[2], 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Tie right after reset: ch0 first, ch1 back-to-back in the next IDLE.
    tick();
    wr = 2'b00;
    adr[31:0]  = 32'h30;
    adr[63:32] = 32'h40;
    req[0] = 2'b11;
    t0 = 0; t1 = 0; d0 = '0; d1 = '0; dual = 1'b0;
    for (int c = 1; c <= 20 && (t0 == 0 || t1 == 0); c++) begin
      tick();
      if (ack[0] == 2'b11) dual = 1'b1;
      if (ack[0][0] && t0 == 0) begin t0 = c; d0 = rdata[0]; req[0][0] = 1'b0; end
      if (ack[0][1] && t1 == 0) begin t1 = c; d1 = rdata[0]; req[0][1] = 1'b0; end
    end
    req[0] = 2'b00;
    check_eq("tie_ch0_lat", t0, 4);
    check_eq("tie_ch1_lat", t1, 9);
    check_eq("tie_ch0_data", d0, 32'hA5000030);
    check_eq("tie_ch1_data", d1, 32'hA5000040);
    check_eq("tie_dual_ack", dual, 0);

    // Second tie goes back to ch0.
    tick();
    req[0] = 2'b11;
    first = '0; fc = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ack[0] != 2'b00) begin first = ack[0]; fc = c; break; end
    end
    req[0] = 2'b00;
    check_eq("tie2_winner", first, 2'b01);
    check_eq("tie2_lat", fc, 4);

    // ch1 drops its request during LATCH; ack still arrives on time.
    tick();
    wr[1] = 1'b0;
    adr[63:32] = 32'h50;
    req[0][1] = 1'b1;
    first = '0; fc = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 2) req[0][1] = 1'b0;
      if (ack[0] != 2'b00) begin first = ack[0]; fc = c; d0 = rdata[0]; break; end
    end
    check_eq("drop_ack", first, 2'b10);
    check_eq("drop_lat", fc, 4);
    check_eq("drop_data", d0, 32'hA5000050);

    // Write then read back on the WAIT=1 instance.
    do_txn(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e, nwe, nre, st);
    check_eq("wr_lat", lat, 4);
    check_eq("wr_we_cycles", nwe, 1);
    check_eq("wr_re_cycles", nre, 0);
    check_eq("wr_err", e, 0);
    check_eq("wr_adr_stable", st, 1);
    do_txn(0, 0, 1'b0, 32'h10, 32'h0, lat, rd, e, nwe, nre, st);
    check_eq("rd_lat", lat, 4);
    check_eq("rd_data", rd, 32'hDEADBEEF);
    check_eq("rd_re_cycles", nre, 1);
    check_eq("rd_we_cycles", nwe, 0);
    check_eq("rd_err", e, 0);
    repeat (3) tick();
    check_eq("rdata_hold", rdata[0], 32'hDEADBEEF);

    // Same read with WAIT=0 and WAIT=7.
    do_txn(1, 0, 1'b0, 32'h20, 32'h0, lat, rd, e, nwe, nre, st);
    check_eq("w0_lat", lat, 3);
    check_eq("w0_data", rd, 32'hA5000020);
    do_txn(2, 0, 1'b0, 32'h20, 32'h0, lat, rd, e, nwe, nre, st);
    check_eq("w7_lat", lat, 10);
    check_eq("w7_data", rd, 32'hA5000020);

    // Out-of-range read at DEPTH.
    do_txn(0, 0, 1'b0, 32'h400, 32'h0, lat, rd, e, nwe, nre, st);
    check_eq("oor_lat", lat, 4);
    check_eq("oor_strobes", nwe + nre, 0);
    check_eq("oor_err", e, 1);
    check_eq("oor_rdata", rd, 0);
    check_eq("oor_adr_stable", st, 1);
    tick();
    check_eq("oor_ack_pulse", ack[0], 0);
    check_eq("oor_err_pulse", err[0], 0);

    // Reset asserted while in WAITS aborts the write without an ack.
    tick();
    wr[0] = 1'b1;
    adr[31:0] = 32'h60;
    wdata[31:0] = 32'h12345678;
    req[0][0] = 1'b1;
    repeat (3) tick();
    check_eq("abort_pre_busy", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy[0], 0);
    check_eq("abort_strobes", {we[0], re[0]}, 0);
    check_eq("abort_ack", ack[0], 0);
    check_eq("abort_ram_adr", ram_adr[0], 0);
    req[0][0] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_eq("abort_idle_first_edge", busy[0], 0);
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (ack[0] != 2'b00 || busy[0]) seen = 1'b1;
    end
    check_eq("abort_no_late_ack", seen, 0);
    do_txn(0, 0, 1'b0, 32'h60, 32'h0, lat, rd, e, nwe, nre, st);
    check_eq("rereq_lat", lat, 4);
    check_eq("rereq_data", rd, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DW, default 32, data word width in bits.
REQ-002 Parameter AW, default 32, address width in bits.
REQ-003 Parameter NCH, default 2, number of requesting channels (2..8).
REQ-004 Parameter WAIT, default 1, extra wait cycles per access (0..7).
REQ-005 Parameter DEPTH, default 1024, number of valid RAM words; addresses >= DEPTH are out of range.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 ch_req  in  NCH  per-channel access request, held until ch_ack.
REQ-009 ch_wr  in  NCH  per-channel direction: 1 write, 0 read.
REQ-010 ch_adr  in  NCH*AW  packed channel addresses, channel i at bits [i*AW +: AW].
REQ-011 ch_wdata  in  NCH*DW  packed channel write data, same packing.
REQ-012 ch_rdata  out  DW  registered read data, valid while ch_ack is high.
REQ-013 ch_ack  out  NCH  one-hot, one-cycle completion pulse to the granted channel.
REQ-014 ch_err  out  1  one-cycle pulse with ch_ack when address was out of range.
REQ-015 ram_adr / ram_din  out  AW / DW  latched address and write data to RAM.
REQ-016 ram_dout  in  DW  synchronous RAM read data, valid the cycle after ram_rd_en.
REQ-017 ram_wr_en / ram_rd_en  out  1 / 1  RAM strobes.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, LATCH, WAITS, DONE.
REQ-020 IDLE: on any ch_req high, grant one channel by round-robin, latch its ch_wr, ch_adr, ch_wdata, and go to ACCESS.
REQ-021 Round-robin: search starts at the channel after the last granted one; after reset, the search starts at channel 0.
REQ-022 ACCESS: for exactly one cycle, assert ram_rd_en (read) or ram_wr_en (write); for an out-of-range address, assert neither; then go to LATCH.
REQ-023 LATCH: for a read, capture ram_dout into the rdata register at the cycle end; for a write, capture nothing; then go to WAITS if WAIT>0, else to DONE.
REQ-024 WAITS: stay for exactly WAIT cycles using a 3-bit down-counter; then go to DONE.
REQ-025 DONE: pulse ch_ack[grant] for one cycle, pulse ch_err if the address was out of range, then go to IDLE.
REQ-026 Latency: ch_req sampled high at edge k gives ch_ack high in cycle k+3+WAIT, identical for reads and writes.
REQ-027 ram_adr and ram_din SHALL stay stable from ACCESS through DONE.
REQ-028 Dropping ch_req mid-transaction SHALL NOT abort it; ch_ack is still pulsed.
REQ-029 New ch_req changes during busy are ignored until IDLE.
REQ-030 Back-to-back: a request pending in the IDLE cycle after DONE is granted in that cycle.
REQ-031 Out-of-range read: ch_rdata SHALL return all-zero.
REQ-032 ch_rdata holds its last value between transactions.

Reset
REQ-033 reset low SHALL asynchronously force: state IDLE, ram_wr_en=0, ram_rd_en=0, ch_ack=0, ch_err=0, busy=0, ch_rdata=0, ram_adr=0, ram_din=0, RR pointer=0, wait counter=0.
REQ-034 Reset mid-transaction SHALL abort it with no ch_ack; the requester must re-request.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the FSM state encoding, the wait-counter width, and the maximum NCH constant.
REQ-036 Sub-module rr_arbiter (NCH-wide request in, one-hot grant out, pointer update on accept) SHALL implement REQ-021.

Verification
REQ-037 NCH=2, WAIT=1: ch0 writes 0xDEADBEEF to 0x10, then reads 0x10 -> ram_wr_en one cycle, ack at k+4, read returns 0xDEADBEEF, ch_err=0.
REQ-038 ch0 and ch1 request in the same cycle, both held -> ch0 acked first, then ch1 granted in the following IDLE; next tie is granted to ch0.
REQ-039 WAIT=0 vs WAIT=7 read of 0x20 -> ack at k+3 and k+10 respectively, same data.
REQ-040 Read from address DEPTH (0x400) -> no RAM strobe, ch_ack and ch_err both high for one cycle, ch_rdata=0.
REQ-041 reset driven low during WAITS -> busy, ram strobes and ch_ack fall immediately; no ack after release; IDLE on the first edge after release.
REQ-042 ch1 drops ch_req in LATCH -> transaction completes, ch_ack[1] pulses at the normal cycle.
